// File: rtl/imuldiv_int_div_iterative.sv
// imuldiv_int_div_iterative
// Iterative 32-bit signed/unsigned divider for the PARC imuldiv subsystem.
// A restoring shift-subtract loop runs over the operand magnitudes for
// 32 cycles. Quotient and remainder come back together as {rem, quot}.
// Optional build macro: IMULDIV_DIV_ZERO_FASTPATH_EN. When it is defined,
// a zero divisor skips the loop and the unit goes straight to DONE with the
// same result bits the full loop would produce.
module imuldiv_int_div_iterative (
    input  logic        clk,
    input  logic        reset,
    input  logic        divreq_msg_fn,
    input  logic [31:0] divreq_msg_a,
    input  logic [31:0] divreq_msg_b,
    input  logic        divreq_val,
    output logic        divreq_rdy,
    output logic [63:0] divresp_msg_result,
    output logic        divresp_val,
    input  logic        divresp_rdy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // 32-bit two's-complement negation; wraps for 0x80000000.
    function automatic logic [31:0] neg32(input logic [31:0] x);
        neg32 = ~x + 32'd1;
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [31:0] divisor_q, divisor_d;
    // Remainder/quotient register. The top bit of the conceptual 65-bit
    // register is always zero between iterations, so only 64 bits are
    // stored and the shifted-out bit is rebuilt inside the subtract.
    logic [63:0] rem_q, rem_d;
    logic        rdy_q, val_q;

    logic        sign_a_s, sign_b_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic [32:0] diff_s;
    logic [31:0] quot_fix_s, rem_fix_s;

    assign sign_a_s = divreq_msg_a[31] & ~divreq_msg_fn;
    assign sign_b_s = divreq_msg_b[31] & ~divreq_msg_fn;
    assign a_mag_s  = sign_a_s ? neg32(divreq_msg_a) : divreq_msg_a;
    assign b_mag_s  = sign_b_s ? neg32(divreq_msg_b) : divreq_msg_b;

    // After the left shift the upper 33 bits are rem_q[63:31].
    assign diff_s = rem_q[63:31] - {1'b0, divisor_q};

    // Sign fix-up of the stored magnitudes; the remainder follows the dividend.
    assign quot_fix_s = (sign_a_q ^ sign_b_q) ? neg32(rem_q[31:0]) : rem_q[31:0];
    assign rem_fix_s  = sign_a_q ? neg32(rem_q[63:32]) : rem_q[63:32];

    assign divreq_rdy         = rdy_q;
    assign divresp_val        = val_q;
    assign divresp_msg_result = {rem_fix_s, quot_fix_s};

    // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (divreq_val) begin
                    sign_a_d  = sign_a_s;
                    sign_b_d  = sign_b_s;
                    divisor_d = b_mag_s;
                    cnt_d     = 5'd31;
`ifdef IMULDIV_DIV_ZERO_FASTPATH_EN
                    if (b_mag_s == 32'd0) begin
                        // Same bits the full loop leaves behind: quot all ones, rem |a|.
                        state_d = ST_DONE;
                        rem_d   = {a_mag_s, 32'hFFFF_FFFF};
                    end else begin
                        state_d = ST_CALC;
                        rem_d   = {32'd0, a_mag_s};
                    end
`else
                    state_d = ST_CALC;
                    rem_d   = {32'd0, a_mag_s};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (diff_s[32] == 1'b0) begin
                    rem_d = {diff_s[31:0], rem_q[30:0], 1'b1};
                end else begin
                    rem_d = {rem_q[62:0], 1'b0};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                if (divresp_rdy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs; synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            divisor_q <= 32'd0;
            rem_q     <= 64'd0;
            rdy_q     <= 1'b1;
            val_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            rdy_q     <= (state_d == ST_IDLE);
            val_q     <= (state_d == ST_DONE);
        end
    end

endmodule

// File: doc/imuldiv_int_div_iterative.md
# imuldiv_int_div_iterative

Iterative 32-bit integer divide/remainder unit for the PARC imuldiv subsystem; it is the divide counterpart to the iterative multiplier. It accepts one request at a time over a val/rdy request interface, runs a restoring shift-subtract loop over operand magnitudes for 32 cycles, and returns quotient and remainder together on a val/rdy response interface. Signed and unsigned operation is selected per request.

## Interface
- No parameters; widths are fixed at 32-bit operands and a 64-bit result.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- divreq_msg_fn  in  1  operation select: 0 = signed, 1 = unsigned.
- divreq_msg_a  in  32  dividend.
- divreq_msg_b  in  32  divisor.
- divreq_val  in  1  request valid.
- divreq_rdy  out  1  request ready; high only in IDLE.
- divresp_msg_result  out  64  result: [63:32] = remainder, [31:0] = quotient.
- divresp_val  out  1  response valid; high only in DONE.
- divresp_rdy  in  1  response ready.

## Operation
- The FSM has three states: IDLE, CALC, DONE.
- **IDLE**
  - divreq_rdy = 1.
  - On divreq_val: latch the operands, go to CALC, and load counter = 31.
  - Operands latched:
    - sign_a = a[31] & ~fn, sign_b = b[31] & ~fn.
    - Divisor register = |b|, computed as two's-complement negation when sign_b is set.
    - 65-bit remainder/quotient register = {33'b0, |a|}.
- **CALC** (one iteration per cycle):
  - Shift the register left by 1.
  - diff = reg[64:32] − {1'b0, divisor}.
  - If diff[32] == 0: reg[64:32] = diff and reg[0] = 1.
  - Otherwise keep the shifted value, with reg[0] = 0.
  - Decrement the counter. The iteration performed while counter == 0 is the last one, then go to DONE.
- **DONE**
  - divresp_val = 1.
  - Result fix-up is combinational from the stored register and sign flags:
    - quotient = (sign_a ^ sign_b) ? −reg[31:0] : reg[31:0].
    - remainder = sign_a ? −reg[63:32] : reg[63:32]; the remainder sign follows the dividend.
  - On divresp_rdy, go to IDLE.
- All negations are 32-bit two's complement; overflow wraps.
  - Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0.
- Divide by zero (full iteration) produces:
  - Magnitude quotient 0xFFFFFFFF and remainder |a|.
  - After fix-up: unsigned gives quot 0xFFFFFFFF, rem a.
  - Signed with a ≥ 0 gives quot 0xFFFFFFFF, rem a.
  - Signed with a < 0 gives quot 0x00000001, rem a.
- Reset in any state:
  - Next state is IDLE and the counter is 0.
  - Sign flags and datapath registers are 0.
  - Any in-flight operation is discarded with no response.

## Timing
- Reset values: divreq_rdy = 1, divresp_val = 0, divresp_msg_result = 0.
- Request handshake occurs on the edge where divreq_val & divreq_rdy (edge 0).
- CALC occupies cycles 1–32.
- divresp_val rises in cycle 33, so latency is 33 cycles from accept to valid.
- Response is held stable while divresp_val & ~divresp_rdy; there is no timeout.
- After the response handshake edge, the unit is in IDLE with divreq_rdy = 1 the next cycle.
- Minimum initiation interval is 34 cycles.
- Requests arriving while not in IDLE see divreq_rdy = 0 and are not consumed.
- Inputs are sampled only on the accept edge; later changes to divreq_msg_* have no effect.

## Configuration
- Macro: IMULDIV_DIV_ZERO_FASTPATH_EN.
- **Defined:** when |b| == 0 at accept, the FSM goes IDLE→DONE directly.
  - The register is loaded so that DONE outputs exactly the divide-by-zero values listed under Operation.
  - Latency is 1 cycle (divresp_val in cycle 1).
- **Undefined:** divide by zero runs the full 32 CALC cycles with identical result bits and 33-cycle latency.
- All other operations are unaffected either way.

## Test plan
- Unsigned 100 / 7 (fn = 1) -> result 0x00000002_0000000E; divresp_val first seen in cycle 33.
- Signed −7 / 2 (a = 0xFFFFFFF9, b = 2) -> 0xFFFFFFFF_FFFFFFFD; signed 7 / −2 -> 0x00000001_FFFFFFFD.
- Signed 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000. Unsigned 0xFFFFFFFF / 1 -> 0x00000000_FFFFFFFF.
- Divide by zero: signed a = 0xFFFFFFF9, b = 0 -> 0xFFFFFFF9_00000001; unsigned a = 5, b = 0 -> 0x00000005_FFFFFFFF. Latency is 1 with IMULDIV_DIV_ZERO_FASTPATH_EN defined and 33 without.
- Backpressure: hold divresp_rdy = 0 for 5 cycles after valid -> result stable and divreq_rdy = 0 throughout; raise divresp_rdy -> divreq_rdy = 1 next cycle; back-to-back second request accepted.
- Assert reset in cycle 10 of CALC -> next cycle divreq_rdy = 1 and divresp_val = 0; a new request of 9 / 3 then returns 0x00000000_00000003.
